// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// ps2_pkg
// Shared definitions for the PS/2 scancode receiver: frame FSM encoding,
// prefix byte values and the list of controller responses that carry no key.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_REL   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  // Bytes that follow E1 in the Pause make sequence.
  localparam int PAUSE_LEN = 7;

  // Controller / BAT responses that are never key codes.
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

endpackage

// File: rtl/ps2_scancode_receiver_if.sv
`timescale 1ns/1ps
// ps2_scancode_receiver_if
// Bundles the raw PS/2 lines and the decoded-code outputs.
//   ps2clk, ps2data  raw PS/2 lines (asynchronous to the system clock)
//   scan_received    one-cycle pulse, code available
//   scancode         final non-prefix byte
//   extended         E0 prefix preceded the code
//   released         F0 prefix preceded the code
//   frame_error      one-cycle pulse on parity/stop failure or timeout
// slave: the receiver; master: the keyboard side / consumer.
interface ps2_scancode_receiver_if;
  logic       ps2clk;
  logic       ps2data;
  logic       scan_received;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       frame_error;

  modport slave (
    input  ps2clk, ps2data,
    output scan_received, scancode, extended, released, frame_error
  );

  modport master (
    output ps2clk, ps2data,
    input  scan_received, scancode, extended, released, frame_error
  );
endinterface

// File: rtl/ps2_input_filter.sv
`timescale 1ns/1ps
// ps2_input_filter
// Synchronizes the raw PS/2 lines and debounces the clock line.
//   clk, rst   system clock, async active-high reset
//   ps2clk     raw PS/2 clock
//   ps2data    raw PS/2 data
//   clk_fall   one-cycle strobe when the filtered clock goes 1 -> 0
//   data_sync  synchronized data line
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2clk,
  input  logic ps2data,
  output logic clk_fall,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync_r;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the filtered level;
  // the level flips on the FILTER_LEN-th such sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync    <= 2'b11;
      data_sync_r <= 2'b11;
      level       <= 1'b1;
      cnt         <= '0;
      clk_fall    <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[0], ps2clk};
      data_sync_r <= {data_sync_r[0], ps2data};
      clk_fall    <= 1'b0;
      if (clk_sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level    <= clk_sync[1];
        cnt      <= '0;
        clk_fall <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign data_sync = data_sync_r[1];

endmodule

// File: rtl/ps2_scancode_receiver.sv
`timescale 1ns/1ps
// ps2_scancode_receiver
// Receives PS/2 keyboard frames and folds E0/F0/E1 prefixes into one
// decoded make/break event per key.
//   clk  system clock
//   rst  async active-high reset
//   bus  ps2_scancode_receiver_if.slave (raw lines in, decoded code out)
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | waiting for a start bit (sampled 0)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking the stop bit, then decoding the byte
module ps2_scancode_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 28000
) (
  input  logic                    clk,
  input  logic                    rst,
  ps2_scancode_receiver_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

  logic clk_fall;
  logic data_sync;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2clk    (bus.ps2clk),
    .ps2data   (bus.ps2data),
    .clk_fall  (clk_fall),
    .data_sync (data_sync)
  );

  frame_state_e state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          par_bit, par_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic [2:0]    pause_cnt, pause_nxt;
  logic          pend_ext, pend_ext_nxt;
  logic          pend_rel, pend_rel_nxt;
  logic [7:0]    code_q, code_nxt;
  logic          ext_q, ext_nxt;
  logic          rel_q, rel_nxt;
  logic          scan_q, scan_nxt;
  logic          ferr_q, ferr_nxt;
  logic          abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      pause_cnt <= '0;
      pend_ext  <= 1'b0;
      pend_rel  <= 1'b0;
      code_q    <= '0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      scan_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      par_bit   <= par_nxt;
      to_cnt    <= to_nxt;
      pause_cnt <= pause_nxt;
      pend_ext  <= pend_ext_nxt;
      pend_rel  <= pend_rel_nxt;
      code_q    <= code_nxt;
      ext_q     <= ext_nxt;
      rel_q     <= rel_nxt;
      scan_q    <= scan_nxt;
      ferr_q    <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    par_nxt      = par_bit;
    to_nxt       = to_cnt;
    pause_nxt    = pause_cnt;
    pend_ext_nxt = pend_ext;
    pend_rel_nxt = pend_rel;
    code_nxt     = code_q;
    ext_nxt      = ext_q;
    rel_nxt      = rel_q;
    scan_nxt     = 1'b0;
    ferr_nxt     = 1'b0;
    abort        = 1'b0;

    if (clk_fall) begin
      // An edge always reloads the timeout, even in the cycle it would expire.
      to_nxt = TO_LOAD;
      case (state)
        ST_IDLE: begin
          if (!data_sync) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          shift_nxt   = {data_sync, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          par_nxt   = data_sync;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (!data_sync || !(^{shift, par_bit})) begin
            abort = 1'b1;
          end else if (pause_cnt != 3'd0) begin
            pause_nxt = pause_cnt - 3'd1;
          end else if (shift == CODE_EXT) begin
            pend_ext_nxt = 1'b1;
          end else if (shift == CODE_REL) begin
            pend_rel_nxt = 1'b1;
          end else if (shift == CODE_PAUSE) begin
            pause_nxt = 3'(PAUSE_LEN);
          end else if (is_ignored(shift)) begin
            pend_ext_nxt = 1'b0;
            pend_rel_nxt = 1'b0;
          end else begin
            scan_nxt     = 1'b1;
            code_nxt     = shift;
            ext_nxt      = pend_ext;
            rel_nxt      = pend_rel;
            pend_ext_nxt = 1'b0;
            pend_rel_nxt = 1'b0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (to_cnt == '0) abort = 1'b1;
      else to_nxt = to_cnt - TW'(1);
    end else begin
      to_nxt = TO_LOAD;
    end

    if (abort) begin
      state_nxt    = ST_IDLE;
      pend_ext_nxt = 1'b0;
      pend_rel_nxt = 1'b0;
      pause_nxt    = '0;
      ferr_nxt     = 1'b1;
      to_nxt       = TO_LOAD;
    end
  end

  assign bus.scan_received = scan_q;
  assign bus.scancode      = code_q;
  assign bus.extended      = ext_q;
  assign bus.released      = rel_q;
  assign bus.frame_error   = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
`timescale 1ns/1ps
// Bench for ps2_scancode_receiver: 1 MHz system clock, 12.5 kHz PS/2 clock
// (40 system cycles per half period), shortened timeout.
module tb_ps2_scancode_receiver;

  localparam int FLEN = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_scancode_receiver_if bus();

  ps2_scancode_receiver #(.FILTER_LEN(FLEN), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #500 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  int obs_err = 0;
  int exp_err = 0;
  int both_cnt = 0;
  int stab_cnt = 0;
  logic [9:0] last_out = '0;

  int m_pause;
  bit m_ext, m_rel;

  // Event recorder, sampled on the falling system-clock edge.
  always @(negedge clk) begin
    if (bus.scan_received === 1'b1)
      obs_q.push_back({bus.extended, bus.released, bus.scancode});
    if (bus.frame_error === 1'b1) obs_err++;
    if (bus.scan_received === 1'b1 && bus.frame_error === 1'b1) both_cnt++;
    if (!rst && bus.scan_received !== 1'b1 &&
        {bus.extended, bus.released, bus.scancode} !== last_out)
      stab_cnt++;
    last_out = {bus.extended, bus.released, bus.scancode};
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input bit glitch = 1'b0);
    bus.ps2data = b;
    if (glitch) begin
      wait_cyc(HALF / 2);
      bus.ps2clk = 1'b0;
      wait_cyc(3);
      bus.ps2clk = 1'b1;
      wait_cyc(HALF / 2 - 3);
    end else begin
      wait_cyc(HALF);
    end
    bus.ps2clk = 1'b0;
    wait_cyc(HALF);
    bus.ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0, input int glitch_bit = -1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i);
    send_bit((~(^b)) ^ bad_par);
    send_bit(~bad_stop);
    bus.ps2data = 1'b1;
    wait_cyc(HALF + 20);
  endtask

  // Reference model: what the keyboard protocol says each frame produces.
  task automatic model_reset();
    m_pause = 0;
    m_ext   = 1'b0;
    m_rel   = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit err);
    if (err) begin
      exp_err++;
      m_pause = 0;
      m_ext   = 1'b0;
      m_rel   = 1'b0;
    end else if (m_pause > 0) begin
      m_pause--;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b == 8'hE1) begin
      m_pause = 7;
    end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      exp_q.push_back({m_ext, m_rel, b});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_err = 0;
  endtask

  task automatic test_reset();
    wait_cyc(5);
    checks++;
    if ({bus.scan_received, bus.frame_error, bus.extended, bus.released, bus.scancode} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000",
               {bus.scan_received, bus.frame_error, bus.extended, bus.released, bus.scancode});
    end
    rst = 1'b0;
    wait_cyc(30);
    checks++;
    if ({bus.scan_received, bus.frame_error, bus.extended, bus.released, bus.scancode} !== 12'h000) begin
      failures++;
      $display("FAIL post_reset_idle got=%h exp=000",
               {bus.scan_received, bus.frame_error, bus.extended, bus.released, bus.scancode});
    end
  endtask

  task automatic test_make();
    clear_obs();
    send_frame(8'h1C);
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL make_count got=%0d exp=1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== {2'b00, 8'h1C}) begin
        failures++;
        $display("FAIL make_code got=%h exp=%h", obs_q[0], {2'b00, 8'h1C});
      end
    end
    checks++;
    if (obs_err !== 0) begin
      failures++;
      $display("FAIL make_err got=%0d exp=0", obs_err);
    end
  endtask

  task automatic test_extended_break();
    clear_obs();
    send_frame(8'hE0);
    send_frame(8'hF0);
    checks++;
    if (obs_q.size() !== 0) begin
      failures++;
      $display("FAIL ext_prefix_pulse got=%0d exp=0", obs_q.size());
    end
    send_frame(8'h75);
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL ext_count got=%0d exp=1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== {2'b11, 8'h75}) begin
        failures++;
        $display("FAIL ext_code got=%h exp=%h", obs_q[0], {2'b11, 8'h75});
      end
    end
  endtask

  task automatic test_errors();
    clear_obs();
    send_frame(8'hE0);
    send_frame(8'h1C, 1'b1);
    checks++;
    if (obs_err !== 1 || obs_q.size() !== 0) begin
      failures++;
      $display("FAIL parity_err errs=%0d pulses=%0d exp errs=1 pulses=0", obs_err, obs_q.size());
    end
    send_frame(8'h1C);
    checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== {2'b00, 8'h1C}) begin
      failures++;
      $display("FAIL after_parity got_n=%0d first=%h exp=%h", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 10'h0, {2'b00, 8'h1C});
    end
    clear_obs();
    send_frame(8'h33, 1'b0, 1'b1);
    checks++;
    if (obs_err !== 1 || obs_q.size() !== 0) begin
      failures++;
      $display("FAIL stop_err errs=%0d pulses=%0d exp errs=1 pulses=0", obs_err, obs_q.size());
    end
  endtask

  task automatic test_glitch_timeout();
    clear_obs();
    bus.ps2data = 1'b0;
    bus.ps2clk  = 1'b0;
    wait_cyc(3);
    bus.ps2clk  = 1'b1;
    bus.ps2data = 1'b1;
    wait_cyc(20);
    send_frame(8'h1C, 1'b0, 1'b0, 3);
    checks++;
    if (obs_err !== 0 || obs_q.size() !== 1 || obs_q[0] !== {2'b00, 8'h1C}) begin
      failures++;
      $display("FAIL glitch errs=%0d n=%0d first=%h exp errs=0 n=1 first=%h", obs_err,
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h0, {2'b00, 8'h1C});
    end
    clear_obs();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (obs_err !== 0) begin
      failures++;
      $display("FAIL timeout_early got=%0d exp=0", obs_err);
    end
    bus.ps2data = 1'b1;
    wait_cyc(TMO + 1);
    checks++;
    if (obs_err !== 1 || obs_q.size() !== 0) begin
      failures++;
      $display("FAIL timeout errs=%0d pulses=%0d exp errs=1 pulses=0", obs_err, obs_q.size());
    end
    clear_obs();
    send_frame(8'h29);
    checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== {2'b00, 8'h29}) begin
      failures++;
      $display("FAIL after_timeout n=%0d first=%h exp=%h", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 10'h0, {2'b00, 8'h29});
    end
  endtask

  task automatic test_pause_ignore();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    clear_obs();
    foreach (seq[i]) send_frame(seq[i]);
    checks++;
    if (obs_q.size() !== 0 || obs_err !== 0) begin
      failures++;
      $display("FAIL pause pulses=%0d errs=%0d exp 0 0", obs_q.size(), obs_err);
    end
    send_frame(8'hAA);
    checks++;
    if (obs_q.size() !== 0) begin
      failures++;
      $display("FAIL ignore_aa got=%0d exp=0", obs_q.size());
    end
    send_frame(8'h5A);
    checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== {2'b00, 8'h5A}) begin
      failures++;
      $display("FAIL after_pause n=%0d first=%h exp=%h", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 10'h0, {2'b00, 8'h5A});
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h12;
    clear_obs();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.scan_received, bus.frame_error, bus.extended, bus.released, bus.scancode} !== 12'h000) begin
      failures++;
      $display("FAIL midframe_reset got=%h exp=000",
               {bus.scan_received, bus.frame_error, bus.extended, bus.released, bus.scancode});
    end
    wait_cyc(5);
    rst = 1'b0;
    bus.ps2data = 1'b1;
    wait_cyc(20);
    send_frame(8'h12);
    checks++;
    if (obs_err !== 0 || obs_q.size() !== 1 || obs_q[0] !== {2'b00, 8'h12}) begin
      failures++;
      $display("FAIL after_reset errs=%0d n=%0d first=%h exp=%h", obs_err, obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 10'h0, {2'b00, 8'h12});
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit err, kind;
    clear_obs();
    exp_q.delete();
    exp_err = 0;
    model_reset();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        3: b = 8'hAA;
        4: b = 8'hFA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      err  = ($urandom_range(0, 9) == 0);
      kind = 1'($urandom_range(0, 1));
      send_frame(b, err & kind, err & ~kind);
      model_frame(b, err);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random_event idx=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (obs_err !== exp_err) begin
      failures++;
      $display("FAIL random_errs got=%0d exp=%0d", obs_err, exp_err);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL both_pulses got=%0d exp=0", both_cnt);
    end
    checks++;
    if (stab_cnt !== 0) begin
      failures++;
      $display("FAIL output_stability changes=%0d exp=0", stab_cnt);
    end
  endtask

  initial begin
    bus.ps2clk  = 1'b1;
    bus.ps2data = 1'b1;
    rst = 1'b1;
    test_reset();
    test_make();
    test_extended_break();
    test_errors();
    test_glitch_timeout();
    test_pause_ignore();
    test_reset_midframe();
    test_random();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
